// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared registered ALU: latches the winning request,
// pulses alu_en, waits LAT cycles and returns the result. Optional macro: ALU_DIVZERO_GUARD_EN.
module alu_arbiter #(
    parameter int unsigned DW  = 19,
    parameter int unsigned OPW = 6,
    parameter int unsigned LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    input  logic [DW-1:0]  req_a0,
    input  logic [DW-1:0]  req_a1,
    input  logic [DW-1:0]  req_b0,
    input  logic [DW-1:0]  req_b1,
    input  logic [2:0]     req_imm0,
    input  logic [2:0]     req_imm1,
    output logic [1:0]     rsp_valid,
    output logic [DW-1:0]  rsp_data,
    output logic [7:0]     rsp_flag,
    output logic           rsp_err,
    output logic           busy,
    output logic [OPW-1:0] alu_opcode,
    output logic [DW-1:0]  alu_r2,
    output logic [DW-1:0]  alu_r3,
    output logic [2:0]     alu_imm,
    output logic           alu_en,
    input  logic [DW-1:0]  alu_r1,
    input  logic [7:0]     alu_flag
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e         state_q, state_d;
    logic           last_grant_q;
    logic           owner_q;
    logic [2:0]     cnt_q;
    logic           grant_valid;
    logic           grant_id;
    logic           accept;
    logic           div_zero;
    logic [OPW-1:0] op_sel;
    logic [DW-1:0]  a_sel;
    logic [DW-1:0]  b_sel;
    logic [2:0]     imm_sel;

    // When both request, the one that did not win last time gets the grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (req_valid)
            2'b01: begin grant_valid = 1'b1; grant_id = 1'b0; end
            2'b10: begin grant_valid = 1'b1; grant_id = 1'b1; end
            2'b11: begin grant_valid = 1'b1; grant_id = ~last_grant_q; end
            default: ;
        endcase
    end

    assign accept  = (state_q == StIdle) && grant_valid;
    assign op_sel  = grant_id ? req_op1  : req_op0;
    assign a_sel   = grant_id ? req_a1   : req_a0;
    assign b_sel   = grant_id ? req_b1   : req_b0;
    assign imm_sel = grant_id ? req_imm1 : req_imm0;

`ifdef ALU_DIVZERO_GUARD_EN
    assign div_zero = (op_sel == OPW'(4)) && (b_sel == '0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = div_zero ? StDone : StIssue;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == 3'(LAT)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (accept) req_ready = 2'b01 << grant_id;
        if (state_q == StDone) rsp_valid = 2'b01 << owner_q;
        alu_en = (state_q == StIssue);
        busy   = (state_q != StIdle);
    end

`ifdef ALU_DIVZERO_GUARD_EN
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 3'd0;
            alu_opcode   <= '0;
            alu_r2       <= '0;
            alu_r3       <= '0;
            alu_imm      <= '0;
            rsp_data     <= '0;
            rsp_flag     <= '0;
`ifdef ALU_DIVZERO_GUARD_EN
            err_q        <= 1'b0;
`endif
        end else begin
            if (accept) begin
                alu_opcode   <= op_sel;
                alu_r2       <= a_sel;
                alu_r3       <= b_sel;
                alu_imm      <= imm_sel;
                owner_q      <= grant_id;
                last_grant_q <= grant_id;
`ifdef ALU_DIVZERO_GUARD_EN
                if (div_zero) begin
                    rsp_data <= '0;
                    rsp_flag <= '0;
                    err_q    <= 1'b1;
                end
`endif
            end
            if (state_q == StIssue) cnt_q <= 3'd1;
            if (state_q == StWait) begin
                if (cnt_q == 3'(LAT)) begin
                    rsp_data <= alu_r1;
                    rsp_flag <= alu_flag;
`ifdef ALU_DIVZERO_GUARD_EN
                    err_q    <= 1'b0;
`endif
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a LAT=1 instance takes the main traffic, a LAT=3 instance
// checks the longer wait; a small behavioural ALU sits behind each.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  who;
        logic [18:0] data;
        logic [7:0]  flag;
        logic        err;
        int          at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   exp_en_a = 0;
    int   en_cnt_a = 0;
    int   en_cnt_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural ALU: result {flag, r1}, flag = {opcode, negative, zero}.
    function automatic logic [26:0] alu_model(input logic [5:0] op, input logic [18:0] a,
                                              input logic [18:0] b, input logic [2:0] imm);
        logic [18:0] r;
        case (op)
            6'd1: r = a + b;
            6'd2: r = a - b;
            6'd3: r = a * b;
            6'd4: r = (b == 19'd0) ? 19'h7FFFF : a / b;
            6'd5: r = a & b;
            6'd6: r = a + {16'd0, imm};
            default: r = 19'd0;
        endcase
        return {op, r[18], (r == 19'd0), r};
    endfunction

    // ---------------- instance A (LAT=1) ----------------
    logic        reset_a;
    logic [1:0]  req_valid_a, req_ready_a, rsp_valid_a;
    logic [5:0]  op0_a, op1_a, alu_opcode_a;
    logic [18:0] a0_a, a1_a, b0_a, b1_a, rsp_data_a, alu_r2_a, alu_r3_a, alu_r1_a;
    logic [2:0]  imm0_a, imm1_a, alu_imm_a;
    logic [7:0]  rsp_flag_a, alu_flag_a;
    logic        rsp_err_a, busy_a, alu_en_a;
    logic [26:0] pipe_a [0:7];

    alu_arbiter #(.DW(19), .OPW(6), .LAT(1)) u_dut_a (
        .clk(clk), .reset(reset_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_op0(op0_a), .req_op1(op1_a), .req_a0(a0_a), .req_a1(a1_a),
        .req_b0(b0_a), .req_b1(b1_a), .req_imm0(imm0_a), .req_imm1(imm1_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_flag(rsp_flag_a),
        .rsp_err(rsp_err_a), .busy(busy_a), .alu_opcode(alu_opcode_a), .alu_r2(alu_r2_a),
        .alu_r3(alu_r3_a), .alu_imm(alu_imm_a), .alu_en(alu_en_a), .alu_r1(alu_r1_a),
        .alu_flag(alu_flag_a)
    );

    always @(posedge clk) begin
        if (reset_a) begin
            for (int k = 0; k < 8; k++) pipe_a[k] <= '0;
        end else begin
            if (alu_en_a) pipe_a[0] <= alu_model(alu_opcode_a, alu_r2_a, alu_r3_a, alu_imm_a);
            for (int k = 1; k < 8; k++) pipe_a[k] <= pipe_a[k-1];
        end
    end
    assign alu_r1_a   = pipe_a[0][18:0];
    assign alu_flag_a = pipe_a[0][26:19];

    always @(negedge clk) begin
        if (alu_en_a) en_cnt_a++;
        if (busy_a) check("ready_outside_idle_a", {30'd0, req_ready_a}, 32'd0);
        if (rsp_valid_a != 2'b00) begin
            if (qa.size() == 0) begin
                check("unexpected_rsp_a", {30'd0, rsp_valid_a}, 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("rsp_owner_a", {30'd0, rsp_valid_a}, {30'd0, e.who});
                check("rsp_cycle_a", cyc, e.at);
                check("rsp_data_a", {13'd0, rsp_data_a}, {13'd0, e.data});
                check("rsp_flag_a", {24'd0, rsp_flag_a}, {24'd0, e.flag});
                check("rsp_err_a", {31'd0, rsp_err_a}, {31'd0, e.err});
            end
        end
    end

    // ---------------- instance B (LAT=3) ----------------
    logic        reset_b;
    logic [1:0]  req_valid_b, req_ready_b, rsp_valid_b;
    logic [5:0]  op0_b, alu_opcode_b;
    logic [18:0] a0_b, b0_b, rsp_data_b, alu_r2_b, alu_r3_b, alu_r1_b;
    logic [2:0]  alu_imm_b;
    logic [7:0]  rsp_flag_b, alu_flag_b;
    logic        rsp_err_b, busy_b, alu_en_b;
    logic [26:0] pipe_b [0:7];

    alu_arbiter #(.DW(19), .OPW(6), .LAT(3)) u_dut_b (
        .clk(clk), .reset(reset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_op0(op0_b), .req_op1(6'd0), .req_a0(a0_b), .req_a1(19'd0),
        .req_b0(b0_b), .req_b1(19'd0), .req_imm0(3'd0), .req_imm1(3'd0),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_flag(rsp_flag_b),
        .rsp_err(rsp_err_b), .busy(busy_b), .alu_opcode(alu_opcode_b), .alu_r2(alu_r2_b),
        .alu_r3(alu_r3_b), .alu_imm(alu_imm_b), .alu_en(alu_en_b), .alu_r1(alu_r1_b),
        .alu_flag(alu_flag_b)
    );

    always @(posedge clk) begin
        if (reset_b) begin
            for (int k = 0; k < 8; k++) pipe_b[k] <= '0;
        end else begin
            if (alu_en_b) pipe_b[0] <= alu_model(alu_opcode_b, alu_r2_b, alu_r3_b, alu_imm_b);
            for (int k = 1; k < 8; k++) pipe_b[k] <= pipe_b[k-1];
        end
    end
    assign alu_r1_b   = pipe_b[2][18:0];
    assign alu_flag_b = pipe_b[2][26:19];

    always @(negedge clk) begin
        if (alu_en_b) en_cnt_b++;
        if (rsp_valid_b != 2'b00) begin
            if (qb.size() == 0) begin
                check("unexpected_rsp_b", {30'd0, rsp_valid_b}, 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("rsp_owner_b", {30'd0, rsp_valid_b}, {30'd0, e.who});
                check("rsp_cycle_b", cyc, e.at);
                check("rsp_data_b", {13'd0, rsp_data_b}, {13'd0, e.data});
                check("rsp_flag_b", {24'd0, rsp_flag_b}, {24'd0, e.flag});
                check("rsp_err_b", {31'd0, rsp_err_b}, {31'd0, e.err});
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the transfer.
    task automatic issue_a(input int i, input logic [5:0] op, input logic [18:0] a,
                           input logic [18:0] b, input logic [2:0] imm, input bit push,
                           input logic [18:0] edata, input logic [7:0] eflag, input logic eerr,
                           input int offs, input bit uses_alu);
        bit   done = 0;
        exp_t e;
        if (i == 0) begin op0_a = op; a0_a = a; b0_a = b; imm0_a = imm; end
        else        begin op1_a = op; a1_a = a; b1_a = b; imm1_a = imm; end
        req_valid_a[i] = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (req_ready_a[i]) begin
                done = 1;
                if (push) begin
                    e.who = 2'b01 << i; e.data = edata; e.flag = eflag; e.err = eerr;
                    e.at = cyc + offs;
                    qa.push_back(e);
                end
                if (uses_alu) exp_en_a++;
            end
            @(negedge clk);
        end
        if (!done) check("accept_timeout_a", 32'd0, 32'd1);
        req_valid_a[i] = 1'b0;
    endtask

    initial begin
        int   grants;
        exp_t e;
        reset_a = 1; reset_b = 1;
        req_valid_a = 0; req_valid_b = 0;
        op0_a = 0; op1_a = 0; a0_a = 0; a1_a = 0; b0_a = 0; b1_a = 0; imm0_a = 0; imm1_a = 0;
        op0_b = 0; a0_b = 0; b0_b = 0;
        repeat (3) @(negedge clk);
        reset_a = 0; reset_b = 0;
        #1;
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_rsp_valid", {30'd0, rsp_valid_a}, 32'd0);
        check("reset_alu_en", {31'd0, alu_en_a}, 32'd0);
        check("reset_rsp_data", {13'd0, rsp_data_a}, 32'd0);
        check("reset_alu_opcode", {26'd0, alu_opcode_a}, 32'd0);
        check("reset_req_ready_idle", {30'd0, req_ready_a}, 32'd0);
        @(negedge clk);

        // ADD 10+15 from requester 0
        issue_a(0, 6'd1, 19'd10, 19'd15, 3'd0, 1, 19'd25, 8'h04, 1'b0, 3, 1);

        // Requester 1 raises valid while busy, then withdraws before being granted
        op1_a = 6'd1; a1_a = 19'd999; b1_a = 19'd1; req_valid_a[1] = 1'b1;
        @(negedge clk); @(negedge clk);
        req_valid_a[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("withdrawn_not_latched", {13'd0, alu_r2_a}, 32'd10);
        check("idle_after_rsp", {31'd0, busy_a}, 32'd0);

        // Unknown opcode passes through; then ADDI from requester 1 exercises imm
        issue_a(0, 6'd63, 19'd7, 19'd9, 3'd0, 1, 19'd0, 8'hFD, 1'b0, 3, 1);
        issue_a(1, 6'd6, 19'd100, 19'd0, 3'd5, 1, 19'd105, 8'h18, 1'b0, 3, 1);
        repeat (4) @(negedge clk);

        // Both valid held: grants alternate 0,1,0
        op0_a = 6'd2; a0_a = 19'd20; b0_a = 19'd5; imm0_a = 0;
        op1_a = 6'd3; a1_a = 19'd3;  b1_a = 19'd4; imm1_a = 0;
        req_valid_a = 2'b11;
        grants = 0;
        for (int t = 0; t < 60 && grants < 3; t++) begin
            #1;
            if (req_ready_a != 2'b00) begin
                check("rr_grant", {30'd0, req_ready_a}, (grants % 2 == 0) ? 32'd1 : 32'd2);
                e.who  = (grants % 2 == 0) ? 2'b01 : 2'b10;
                e.data = (grants % 2 == 0) ? 19'd15 : 19'd12;
                e.flag = (grants % 2 == 0) ? 8'h08 : 8'h0C;
                e.err = 1'b0; e.at = cyc + 3;
                qa.push_back(e);
                exp_en_a++;
                grants++;
            end
            @(negedge clk);
        end
        check("rr_grant_count", grants, 3);
        req_valid_a = 2'b00;

        // Non-zero divide on requester 1
        issue_a(1, 6'd4, 19'd100, 19'd7, 3'd0, 1, 19'd14, 8'h10, 1'b0, 3, 1);
        repeat (4) @(negedge clk);

        // Reset during WAIT drops the result and restores last_grant=1
        issue_a(0, 6'd1, 19'd1, 19'd2, 3'd0, 0, 19'd0, 8'h00, 1'b0, 0, 1);
        @(negedge clk);
        reset_a = 1;
        @(negedge clk);
        check("reset_wait_busy", {31'd0, busy_a}, 32'd0);
        check("reset_wait_rsp", {30'd0, rsp_valid_a}, 32'd0);
        reset_a = 0;
        op0_a = 6'd5; a0_a = 19'h55555; b0_a = 19'h66666;
        op1_a = 6'd1; a1_a = 19'd1; b1_a = 19'd1;
        req_valid_a = 2'b11;
        #1;
        check("post_reset_grant", {30'd0, req_ready_a}, 32'd1);
        e.who = 2'b01; e.data = 19'h44444; e.flag = 8'h16; e.err = 1'b0; e.at = cyc + 3;
        qa.push_back(e);
        exp_en_a++;
        @(negedge clk);
        req_valid_a = 2'b00;
        repeat (4) @(negedge clk);

        // Divide by zero
`ifdef ALU_DIVZERO_GUARD_EN
        issue_a(0, 6'd4, 19'd10, 19'd0, 3'd0, 1, 19'd0, 8'h00, 1'b1, 1, 0);
`else
        issue_a(0, 6'd4, 19'd10, 19'd0, 3'd0, 1, 19'h7FFFF, 8'h12, 1'b0, 3, 1);
`endif

        // LAT=3 instance: AND
        op0_b = 6'd5; a0_b = 19'h55555; b0_b = 19'h66666; req_valid_b = 2'b01;
        #1;
        check("lat3_ready", {30'd0, req_ready_b}, 32'd1);
        e.who = 2'b01; e.data = 19'h44444; e.flag = 8'h16; e.err = 1'b0; e.at = cyc + 5;
        qb.push_back(e);
        @(negedge clk);
        req_valid_b = 2'b00;

        for (int t = 0; t < 100 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clk);
        check("pending_rsp_a", qa.size(), 0);
        check("pending_rsp_b", qb.size(), 0);
        repeat (3) @(negedge clk);
        check("alu_en_cycles_a", en_cnt_a, exp_en_a);
        check("alu_en_cycles_b", en_cnt_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
